// File: rtl/buffer_m_pkg.sv
// Shared types and defaults for the buffer_m writable meta-data buffer.
// Optional macro BUFFER_M_WR_FWD_EN (see buffer_m_writer) enables
// same-address write-to-read forwarding.
package buffer_m_pkg;

  // Default geometry: 256 entries of 16 bits.
  localparam int BUFFER_M_ADDR_LEN_DEFAULT = 8;
  localparam int BUFFER_M_DATA_LEN_DEFAULT = 16;

  // Load controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } buffer_m_state_e;

  // The stream is open (wr_ready high) only while loading or draining.
  function automatic logic is_stream_state(input buffer_m_state_e st);
    return (st == LOAD) || (st == DRAIN);
  endfunction

endpackage

// File: rtl/buffer_m_writer_ram_1r1w.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Read-first: a read and write to the same address in one cycle returns
// the old contents. Written so synthesis maps it onto block RAM.
module ram_1r1w #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_reg;

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; no reset so it stays a plain block-RAM output.
  always_ff @(posedge clk) begin
    rd_data_reg <= mem[rd_addr];
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/buffer_m_writer.sv
// buffer_m_writer: run-time loadable meta-data buffer for one PE.
// A valid/ready stream fills the RAM from address 0; the PE reads it through
// a one-cycle registered port. Loads longer than the RAM are drained and
// flagged with trunc_err.
// Optional macro: BUFFER_M_WR_FWD_EN -- when defined, a write and a read of
// the same address in one cycle return the new data on the next cycle;
// otherwise the read returns the old contents (read-first).
module buffer_m_writer
  import buffer_m_pkg::*;
#(
  parameter int addrLen = BUFFER_M_ADDR_LEN_DEFAULT,
  parameter int dataLen = BUFFER_M_DATA_LEN_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_start,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [dataLen-1:0] wr_data,
  input  logic               wr_last,
  input  logic [addrLen-1:0] rd_addr,
  output logic [dataLen-1:0] data_out,
  output logic               load_done,
  output logic [addrLen:0]   word_count,
  output logic               trunc_err
);

  // word_count value meaning "RAM completely filled".
  localparam logic [addrLen:0]   DEPTH_CNT = {1'b1, {addrLen{1'b0}}};
  localparam logic [addrLen-1:0] LAST_ADDR = {addrLen{1'b1}};

  buffer_m_state_e    state_reg, state_next;
  logic [addrLen-1:0] wr_addr_reg, wr_addr_next;
  logic [addrLen:0]   word_count_reg, word_count_next;
  logic               trunc_err_reg, trunc_err_next;
  logic               mem_we;
  logic               beat;
  logic [dataLen-1:0] ram_rd_data;
  logic [dataLen-1:0] rd_sel;
  logic               rd_live_reg;

  // wr_ready decodes the state register only, never wr_valid.
  assign wr_ready   = is_stream_state(state_reg);
  assign load_done  = (state_reg == DONE);
  assign word_count = word_count_reg;
  assign trunc_err  = trunc_err_reg;
  assign beat       = wr_valid && wr_ready;

  // State and counter registers; reset aborts any load in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      wr_addr_reg    <= '0;
      word_count_reg <= '0;
      trunc_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wr_addr_reg    <= wr_addr_next;
      word_count_reg <= word_count_next;
      trunc_err_reg  <= trunc_err_next;
    end
  end

  // Next-state, write strobe and counter updates.
  always_comb begin
    state_next      = state_reg;
    wr_addr_next    = wr_addr_reg;
    word_count_next = word_count_reg;
    trunc_err_next  = trunc_err_reg;
    mem_we          = 1'b0;

    if (load_start) begin
      // A restart wins over any beat in the same cycle; that beat is dropped.
      state_next      = LOAD;
      wr_addr_next    = '0;
      word_count_next = '0;
      trunc_err_next  = 1'b0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (beat) begin
            mem_we       = 1'b1;
            wr_addr_next = wr_addr_reg + 1'b1;
            if (word_count_reg != DEPTH_CNT) begin
              word_count_next = word_count_reg + 1'b1;
            end
            if (wr_last) begin
              state_next = DONE;
            end else if (wr_addr_reg == LAST_ADDR) begin
              // RAM is full but the stream continues: swallow the rest.
              state_next     = DRAIN;
              trunc_err_next = 1'b1;
            end
          end
        end
        DRAIN: begin
          if (beat && wr_last) begin
            state_next = DONE;
          end
        end
        IDLE, DONE: begin
          state_next = state_reg;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  ram_1r1w #(
    .ADDR_W(addrLen),
    .DATA_W(dataLen)
  ) u_ram (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (wr_addr_reg),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (ram_rd_data)
  );

`ifdef BUFFER_M_WR_FWD_EN
  logic               fwd_hit_reg;
  logic [dataLen-1:0] fwd_data_reg;

  // Capture a same-cycle write to the address being read, so the new
  // value can bypass the read-first RAM output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fwd_hit_reg  <= 1'b0;
      fwd_data_reg <= '0;
    end else begin
      fwd_hit_reg  <= mem_we && (wr_addr_reg == rd_addr);
      fwd_data_reg <= wr_data;
    end
  end

  assign rd_sel = fwd_hit_reg ? fwd_data_reg : ram_rd_data;
`else
  assign rd_sel = ram_rd_data;
`endif

  // Marks that the RAM read register holds a read taken out of reset;
  // data_out is forced to zero until then without resetting the RAM itself.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_live_reg <= 1'b0;
    end else begin
      rd_live_reg <= 1'b1;
    end
  end

  assign data_out = rd_live_reg ? rd_sel : '0;

endmodule

// File: tb/tb_buffer_m_writer.sv
// Table-driven bench for buffer_m_writer with a 4-entry RAM (addrLen=2).
// Each table row is one clock cycle: inputs driven at the falling edge,
// outputs compared 1 ns after the following rising edge.
module tb_buffer_m_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        wr_last;
  logic [1:0]  rd_addr;
  logic [15:0] data_out;
  logic        load_done;
  logic [2:0]  word_count;
  logic        trunc_err;

  int checks = 0;
  int errors = 0;

`ifdef BUFFER_M_WR_FWD_EN
  localparam int EXP_COLL = 'h55AA;
`else
  localparam int EXP_COLL = 'h1234;
`endif

  always #5 clk = ~clk;

  buffer_m_writer #(
    .addrLen(2),
    .dataLen(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .rd_addr    (rd_addr),
    .data_out   (data_out),
    .load_done  (load_done),
    .word_count (word_count),
    .trunc_err  (trunc_err)
  );

  typedef struct {
    logic        rst_n;
    logic        ls;
    logic        v;
    logic [15:0] d;
    logic        l;
    logic [1:0]  ra;
    logic        e_rdy;
    logic        e_done;
    logic [2:0]  e_wc;
    logic        e_te;
    logic [15:0] e_dout;
    logic        cd;
  } vec_t;

  vec_t vecs[$];

  task automatic r(input int rst_n, input int ls, input int v, input int d,
                   input int l, input int ra, input int e_rdy, input int e_done,
                   input int e_wc, input int e_te, input int e_dout, input int cd);
    vec_t x;
    x.rst_n  = 1'(rst_n);
    x.ls     = 1'(ls);
    x.v      = 1'(v);
    x.d      = 16'(d);
    x.l      = 1'(l);
    x.ra     = 2'(ra);
    x.e_rdy  = 1'(e_rdy);
    x.e_done = 1'(e_done);
    x.e_wc   = 3'(e_wc);
    x.e_te   = 1'(e_te);
    x.e_dout = 16'(e_dout);
    x.cd     = 1'(cd);
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d got %h expected %h", name, row, got, exp);
    end
  endtask

  initial begin
    reset      = 1'b0;
    load_start = 1'b0;
    wr_valid   = 1'b0;
    wr_data    = '0;
    wr_last    = 1'b0;
    rd_addr    = '0;

    //  rst ls v  data   l  ra | rdy done wc te dout    chk
    // Reset and basic load 0x11..0x44
    r(0, 0, 0, 'h0000, 0, 0,   0, 0, 0, 0, 'h0000, 1);
    r(1, 0, 0, 'h0000, 0, 0,   0, 0, 0, 0, 'h0000, 0);
    r(1, 1, 0, 'h0000, 0, 0,   1, 0, 0, 0, 'h0000, 0);
    r(1, 0, 1, 'h0011, 0, 3,   1, 0, 1, 0, 'h0000, 0);
    r(1, 0, 1, 'h0022, 0, 0,   1, 0, 2, 0, 'h0011, 1);
    r(1, 0, 1, 'h0033, 0, 1,   1, 0, 3, 0, 'h0022, 1);
    r(1, 0, 1, 'h0044, 1, 2,   0, 1, 4, 0, 'h0033, 1);
    r(1, 0, 0, 'h0000, 0, 3,   0, 1, 4, 0, 'h0044, 1);
    r(1, 0, 1, 'hBEEF, 1, 0,   0, 1, 4, 0, 'h0011, 1);
    r(1, 0, 0, 'h0000, 0, 0,   0, 1, 4, 0, 'h0011, 1);
    // Overflow: 6 beats into 4 entries
    r(1, 1, 0, 'h0000, 0, 0,   1, 0, 0, 0, 'h0011, 1);
    r(1, 0, 1, 'h0001, 0, 3,   1, 0, 1, 0, 'h0000, 0);
    r(1, 0, 1, 'h0002, 0, 3,   1, 0, 2, 0, 'h0000, 0);
    r(1, 0, 1, 'h0003, 0, 3,   1, 0, 3, 0, 'h0000, 0);
    r(1, 0, 1, 'h0004, 0, 1,   1, 0, 4, 1, 'h0002, 1);
    r(1, 0, 1, 'h0005, 0, 0,   1, 0, 4, 1, 'h0001, 1);
    r(1, 0, 1, 'h0006, 1, 3,   0, 1, 4, 1, 'h0004, 1);
    r(1, 0, 0, 'h0000, 0, 0,   0, 1, 4, 1, 'h0001, 1);
    r(1, 0, 0, 'h0000, 0, 1,   0, 1, 4, 1, 'h0002, 1);
    r(1, 0, 0, 'h0000, 0, 2,   0, 1, 4, 1, 'h0003, 1);
    // Backpressure: valid 1,0,0,1,1,0,1 (last without valid ignored)
    r(1, 1, 0, 'h0000, 0, 0,   1, 0, 0, 0, 'h0001, 1);
    r(1, 0, 1, 'h0011, 0, 3,   1, 0, 1, 0, 'h0000, 0);
    r(1, 0, 0, 'hDEAD, 0, 3,   1, 0, 1, 0, 'h0000, 0);
    r(1, 0, 0, 'hDEAD, 1, 3,   1, 0, 1, 0, 'h0000, 0);
    r(1, 0, 1, 'h0022, 0, 3,   1, 0, 2, 0, 'h0000, 0);
    r(1, 0, 1, 'h0033, 0, 3,   1, 0, 3, 0, 'h0000, 0);
    r(1, 0, 0, 'hDEAD, 0, 3,   1, 0, 3, 0, 'h0000, 0);
    r(1, 0, 1, 'h0044, 1, 0,   0, 1, 4, 0, 'h0011, 1);
    r(1, 0, 0, 'h0000, 0, 1,   0, 1, 4, 0, 'h0022, 1);
    r(1, 0, 0, 'h0000, 0, 2,   0, 1, 4, 0, 'h0033, 1);
    r(1, 0, 0, 'h0000, 0, 3,   0, 1, 4, 0, 'h0044, 1);
    // Exact fill: last on the 4th beat, no truncation
    r(1, 1, 0, 'h0000, 0, 0,   1, 0, 0, 0, 'h0011, 1);
    r(1, 0, 1, 'h0101, 0, 3,   1, 0, 1, 0, 'h0000, 0);
    r(1, 0, 1, 'h0202, 0, 3,   1, 0, 2, 0, 'h0000, 0);
    r(1, 0, 1, 'h0303, 0, 3,   1, 0, 3, 0, 'h0000, 0);
    r(1, 0, 1, 'h0404, 1, 0,   0, 1, 4, 0, 'h0101, 1);
    r(1, 0, 0, 'h0000, 0, 3,   0, 1, 4, 0, 'h0404, 1);
    // Restart after 2 beats; beat in the restart cycle is dropped
    r(1, 1, 0, 'h0000, 0, 0,   1, 0, 0, 0, 'h0101, 1);
    r(1, 0, 1, 'h1111, 0, 3,   1, 0, 1, 0, 'h0000, 0);
    r(1, 0, 1, 'h2222, 0, 3,   1, 0, 2, 0, 'h0000, 0);
    r(1, 1, 1, 'h9999, 0, 3,   1, 0, 0, 0, 'h0404, 1);
    r(1, 0, 1, 'h000A, 0, 3,   1, 0, 1, 0, 'h0404, 1);
    r(1, 0, 1, 'h000B, 0, 3,   1, 0, 2, 0, 'h0404, 1);
    r(1, 0, 1, 'h000C, 1, 0,   0, 1, 3, 0, 'h000A, 1);
    r(1, 0, 0, 'h0000, 0, 1,   0, 1, 3, 0, 'h000B, 1);
    r(1, 0, 0, 'h0000, 0, 2,   0, 1, 3, 0, 'h000C, 1);
    r(1, 0, 0, 'h0000, 0, 3,   0, 1, 3, 0, 'h0404, 1);
    // Same-address collision at address 0
    r(1, 1, 0, 'h0000, 0, 3,   1, 0, 0, 0, 'h0404, 1);
    r(1, 0, 1, 'h1234, 1, 3,   0, 1, 1, 0, 'h0404, 1);
    r(1, 1, 0, 'h0000, 0, 3,   1, 0, 0, 0, 'h0404, 1);
    r(1, 0, 1, 'h55AA, 1, 0,   0, 1, 1, 0, EXP_COLL, 1);
    r(1, 0, 0, 'h0000, 0, 0,   0, 1, 1, 0, 'h55AA, 1);
    // Reset while draining, then stay idle despite valid beats
    r(1, 1, 0, 'h0000, 0, 0,   1, 0, 0, 0, 'h55AA, 1);
    r(1, 0, 1, 'h0E01, 0, 3,   1, 0, 1, 0, 'h0404, 1);
    r(1, 0, 1, 'h0E02, 0, 3,   1, 0, 2, 0, 'h0404, 1);
    r(1, 0, 1, 'h0E03, 0, 3,   1, 0, 3, 0, 'h0404, 1);
    r(1, 0, 1, 'h0E04, 0, 1,   1, 0, 4, 1, 'h0E02, 1);
    r(0, 0, 1, 'h0E05, 0, 3,   0, 0, 0, 0, 'h0000, 1);
    r(1, 0, 1, 'h0E06, 1, 3,   0, 0, 0, 0, 'h0E04, 1);
    r(1, 0, 1, 'h0E07, 1, 2,   0, 0, 0, 0, 'h0E03, 1);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset      = vecs[i].rst_n;
      load_start = vecs[i].ls;
      wr_valid   = vecs[i].v;
      wr_data    = vecs[i].d;
      wr_last    = vecs[i].l;
      rd_addr    = vecs[i].ra;
      @(posedge clk);
      #1;
      $display("row %0d rst=%0b ls=%0b v=%0b d=%h l=%0b ra=%0d -> rdy=%0b done=%0b wc=%0d te=%0b dout=%h",
               i, vecs[i].rst_n, vecs[i].ls, vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].ra,
               wr_ready, load_done, word_count, trunc_err, data_out);
      chk("wr_ready", i, 32'(wr_ready), 32'(vecs[i].e_rdy));
      chk("load_done", i, 32'(load_done), 32'(vecs[i].e_done));
      chk("word_count", i, 32'(word_count), 32'(vecs[i].e_wc));
      chk("trunc_err", i, 32'(trunc_err), 32'(vecs[i].e_te));
      if (vecs[i].cd) begin
        chk("data_out", i, 32'(data_out), 32'(vecs[i].e_dout));
      end
    end

    // Back-to-back stream from IDLE: one beat per cycle, bounded wait for done.
    @(negedge clk);
    reset      = 1'b1;
    load_start = 1'b1;
    wr_valid   = 1'b0;
    wr_last    = 1'b0;
    @(negedge clk);
    load_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("stream_ready", 100 + k, 32'(wr_ready), 32'd1);
      wr_valid = 1'b1;
      wr_data  = 16'hC000 + 16'(k);
      wr_last  = (k == 3);
      rd_addr  = 2'd0;
      @(negedge clk);
      $display("stream beat %0d d=%h -> rdy=%0b done=%0b wc=%0d", k, wr_data,
               wr_ready, load_done, word_count);
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    begin
      int waited = 0;
      while (!load_done && waited < 4) begin
        @(negedge clk);
        waited++;
      end
      chk("stream_done_latency", 104, 32'(waited), 32'd0);
    end
    chk("stream_word_count", 105, 32'(word_count), 32'd4);
    rd_addr = 2'd2;
    @(negedge clk);
    chk("stream_read", 106, 32'(data_out), 32'h0000C002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
